// File: rtl/gate_tv_sequencer_pkg.sv
// gate_tv_pkg: shared state encodings, truth-table constants and vector count for the gate sweep checker
`timescale 1ns/1ps
package gate_tv_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam int NUM_VEC = 4;
   typedef enum logic [1:0] {IDLE = ST_IDLE, DRIVE = ST_DRIVE, DONE = ST_DONE} state_t;
endpackage

// File: rtl/gate_tv_sequencer_if.sv
// gate_tv_sequencer_if: control, gate stimulus/response and result signals of the sequencer
`timescale 1ns/1ps
interface gate_tv_sequencer_if;
   logic start;
   logic dut_a;
   logic dut_b;
   logic dut_out;
   logic busy;
   logic done;
   logic pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;
   modport master (output start, dut_out, input dut_a, dut_b, busy, done, pass, err_count, fail_vec);
   modport slave (input start, dut_out, output dut_a, dut_b, busy, done, pass, err_count, fail_vec);
endinterface

// File: rtl/gate_tv_sequencer_dwell_timer.sv
// dwell_timer: counts 0..DWELL_CYCLES-1 while enabled, pulsing expire on the last count and wrapping to 0
`timescale 1ns/1ps
module dwell_timer #(parameter int DWELL_CYCLES = 100) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int W = $clog2(DWELL_CYCLES);
   logic [W-1:0] cnt;
   assign expire = en && cnt == W'(DWELL_CYCLES - 1);
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= expire ? '0 : cnt + 1'b1;
endmodule

// File: rtl/gate_tv_sequencer.sv
// gate_tv_sequencer: drives {a,b}=00,01,10,11 into a gate, samples each on its last dwell cycle, checks vs TRUTH
// Build option GATE_TV_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
`timescale 1ns/1ps
module gate_tv_sequencer
   import gate_tv_pkg::*;
#(
   parameter int DWELL_CYCLES = 100,
   parameter logic [3:0] TRUTH = TT_AND
) (
   input logic clk_50M,
   input logic reset,
   gate_tv_sequencer_if.slave bus
);
   state_t state, next;
   logic [1:0] idx, idx_n;
   logic expire, accept, mismatch, stop;
   logic a, b, pass;
   logic [2:0] err, err_n;
   logic [3:0] fail, fail_n;
   dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
      .clk(clk_50M), .rst(reset), .clr(state != DRIVE), .en(state == DRIVE), .expire(expire)
   );
   always_comb begin
      accept = state == IDLE && bus.start;
      mismatch = expire && bus.dut_out != TRUTH[idx];
`ifdef GATE_TV_STOP_ON_FAIL_EN
      stop = expire && (idx == 2'(NUM_VEC - 1) || mismatch);
`else
      stop = expire && idx == 2'(NUM_VEC - 1);
`endif
      next = accept ? DRIVE : stop ? DONE : state == DONE ? IDLE : state;
      idx_n = state != DRIVE ? 2'd0 : (expire && !stop) ? idx + 2'd1 : idx;
      // err_count tops out at 4 because each of the four vectors contributes at most once
      err_n = accept ? 3'd0 : err + {2'b0, mismatch};
      fail_n = accept ? 4'd0 : fail | ({3'b0, mismatch} << idx);
   end
   always_ff @(posedge clk_50M)
      if (reset) begin
         state <= IDLE;
         idx <= 2'd0;
         a <= 1'b0;
         b <= 1'b0;
         pass <= 1'b0;
         err <= 3'd0;
         fail <= 4'd0;
      end else begin
         state <= next;
         idx <= idx_n;
         a <= next == DRIVE && idx_n[1];
         b <= next == DRIVE && idx_n[0];
         pass <= accept ? 1'b0 : next == DONE ? err_n == 3'd0 : pass;
         err <= err_n;
         fail <= fail_n;
      end
   assign bus.dut_a = a;
   assign bus.dut_b = b;
   assign bus.busy = state == DRIVE;
   assign bus.done = state == DONE;
   assign bus.pass = pass;
   assign bus.err_count = err;
   assign bus.fail_vec = fail;
endmodule

// File: tb/tb_gate_tv_sequencer.sv
// tb_gate_tv_sequencer: directed sweeps of the sequencer against AND, stuck-at-0 and OR gates
`timescale 1ns/1ps
module tb_gate_tv_sequencer;
   import gate_tv_pkg::*;
   logic clk_50M = 1'b0;
   logic reset = 1'b1;
   int gsel = 0;
   int n_vec = 0;
   int n_bad = 0;
   gate_tv_sequencer_if bus ();
   gate_tv_sequencer #(.DWELL_CYCLES(4), .TRUTH(TT_AND)) dut (.clk_50M(clk_50M), .reset(reset), .bus(bus));
   always #5 clk_50M = ~clk_50M;
   assign bus.dut_out = gsel == 0 ? (bus.dut_a & bus.dut_b) : gsel == 1 ? 1'b0 : (bus.dut_a | bus.dut_b);

   task automatic tick();
      @(posedge clk_50M);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_results(input string tag, input logic p, input logic [2:0] e, input logic [3:0] f);
      chk({tag, "_busy"}, 8'(bus.busy), 8'd0);
      chk({tag, "_done"}, 8'(bus.done), 8'd0);
      chk({tag, "_ab"}, 8'({bus.dut_a, bus.dut_b}), 8'd0);
      chk({tag, "_pass"}, 8'(bus.pass), 8'(p));
      chk({tag, "_err"}, 8'(bus.err_count), 8'(e));
      chk({tag, "_fail"}, 8'(bus.fail_vec), 8'(f));
   endtask

   // Start in the current cycle, then follow the sweep cycle by cycle through done and one idle cycle.
   task automatic sweep(input int nvec, input logic p, input logic [2:0] e, input logic [3:0] f, input bit extra);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= nvec * 4; c++) begin
         if (c == 1) begin
            chk("clr_pass", 8'(bus.pass), 8'd0);
            chk("clr_err", 8'(bus.err_count), 8'd0);
            chk("clr_fail", 8'(bus.fail_vec), 8'd0);
         end
         chk("busy", 8'(bus.busy), 8'd1);
         chk("ab", 8'({bus.dut_a, bus.dut_b}), 8'((c - 1) / 4));
         chk("done_early", 8'(bus.done), 8'd0);
         bus.start = extra && c == 3;
         tick();
         bus.start = 1'b0;
      end
      chk("done", 8'(bus.done), 8'd1);
      chk("done_busy", 8'(bus.busy), 8'd0);
      chk("done_ab", 8'({bus.dut_a, bus.dut_b}), 8'd0);
      chk("done_pass", 8'(bus.pass), 8'(p));
      chk("done_err", 8'(bus.err_count), 8'(e));
      chk("done_fail", 8'(bus.fail_vec), 8'(f));
      bus.start = extra;
      tick();
      bus.start = 1'b0;
      idle_results("after", p, e, f);
   endtask

   initial begin
      bus.start = 1'b1;
      tick();
      tick();
      idle_results("reset", 1'b0, 3'd0, 4'd0);
      reset = 1'b0;
      bus.start = 1'b0;
      tick();
      idle_results("idle", 1'b0, 3'd0, 4'd0);

      gsel = 0;
      sweep(4, 1'b1, 3'd0, 4'b0000, 1'b0);
      gsel = 1;
      sweep(4, 1'b0, 3'd1, 4'b1000, 1'b0);
      gsel = 2;
`ifdef GATE_TV_STOP_ON_FAIL_EN
      sweep(2, 1'b0, 3'd1, 4'b0010, 1'b0);
`else
      sweep(4, 1'b0, 3'd2, 4'b0110, 1'b0);
`endif
      tick();
      idle_results("hold", 1'b0, 3'd1 + 3'(`ifdef GATE_TV_STOP_ON_FAIL_EN 0 `else 1 `endif), `ifdef GATE_TV_STOP_ON_FAIL_EN 4'b0010 `else 4'b0110 `endif);

      gsel = 0;
      sweep(4, 1'b1, 3'd0, 4'b0000, 1'b1);
      for (int i = 0; i < 6; i++) begin
         chk("no_restart_busy", 8'(bus.busy), 8'd0);
         chk("no_second_done", 8'(bus.done), 8'd0);
         tick();
      end

`ifdef GATE_TV_STOP_ON_FAIL_EN
      gsel = 1;
`else
      gsel = 2;
`endif
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 9; c++) tick();
      chk("pre_abort_busy", 8'(bus.busy), 8'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_results("abort", 1'b0, 3'd0, 4'd0);
      for (int i = 0; i < 20; i++) begin
         chk("abort_no_done", 8'(bus.done | bus.busy), 8'd0);
         tick();
      end

      gsel = 0;
      sweep(4, 1'b1, 3'd0, 4'b0000, 1'b0);
      gsel = 1;
      sweep(4, 1'b0, 3'd1, 4'b1000, 1'b0);
      gsel = 0;
      sweep(4, 1'b1, 3'd0, 4'b0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
